// File: rtl/wd_sigverify_pkg.sv
// wd_sigverify: shared sigverify beat/metadata types, plus the beat size used by the PCIe ingress extractor.
package wd_sigverify;

    localparam logic [31:0] PCIE_MAGIC      = 32'h5043_4945;
    localparam int          PCIE_BEAT_BYTES = 64;

    typedef struct packed {
        logic [31:0]  magic;
        logic [63:0]  tid;
        logic [15:0]  src;
        logic [15:0]  size;
        logic [5:0]   emp;
        logic [121:0] rsvd;
        logic [255:0] sig_l;
    } pcie_meta_t;

    typedef struct packed {
        logic         sop;
        logic [255:0] pub;
        logic [255:0] sig_h;
        logic [511:0] data;
    } sv_meta2_t;

    typedef struct packed {
        logic       eop;
        sv_meta2_t  m0;
        pcie_meta_t m1;
    } pcie_tr_word_t;

endpackage

// File: rtl/pcie_tr_ch.sv
// pcie_tr_ch: one ingress channel -- header parser (IDLE/BODY/DROP) feeding a show-ahead FIFO.
// PCIE_TR_EXT_MC_STATS_EN adds per-channel packet and error counters.
module pcie_tr_ch
    import wd_sigverify::*;
#(
    parameter int          BUFF_SZ   = 1024,
    parameter int          MAX_BEATS = 16,
    parameter logic [63:0] TID_RST   = 64'hABCD_0000,
    localparam int         BUFF_SZ_L = $clog2(BUFF_SZ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               v,
    input  logic [511:0]       d,
    input  logic               rd,
    output pcie_tr_word_t      q,
    output logic               empty,
    output logic               full,
    output logic [BUFF_SZ_L:0] fill,
    output logic               ovf
`ifdef PCIE_TR_EXT_MC_STATS_EN
    ,
    output logic [31:0]        pkt_cnt,
    output logic [31:0]        err_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, BODY, DROP} st_t;

    st_t           st, st_nx;
    pcie_meta_t    hd, hm, meta_q;
    pcie_tr_word_t wd_q;
    logic [15:0]   tc, tc_q, cnt_q;
    logic [63:0]   tid_q;
    logic          hdr, wr_q, first, last;

    assign hd    = d;
    assign hdr   = v && st == IDLE && hd.magic == PCIE_MAGIC;
    assign tc    = (hd.size >> 6) + 16'(|hd.size[5:0]);
    assign first = cnt_q == 16'd1;
    assign last  = cnt_q == tc_q;

    // Packet metadata as it travels with every body beat: channel tid and empty-byte count replace header fields.
    always_comb begin
        hm     = hd;
        hm.tid = tid_q;
        hm.emp = 6'(PCIE_BEAT_BYTES - int'(hd.size));
        st_nx  = st;
        if (hdr)
            st_nx = hd.size == '0 ? IDLE : (tc > 16'(MAX_BEATS) ? DROP : BODY);
        else if (v && st != IDLE && last)
            st_nx = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) st <= IDLE;
        else        st <= st_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tid_q  <= TID_RST;
            meta_q <= '0;
            tc_q   <= '0;
            cnt_q  <= '0;
            wr_q   <= 1'b0;
            wd_q   <= '0;
            ovf    <= 1'b0;
        end else begin
            wr_q <= v && st == BODY;
            if (hdr) begin
                meta_q <= hm;
                tc_q   <= tc;
                cnt_q  <= 16'd1;
                tid_q  <= tid_q + 64'd1;
            end else if (v && st != IDLE) begin
                cnt_q <= cnt_q + 16'd1;
            end
            if (v && st == BODY) begin
                wd_q.eop     <= last;
                wd_q.m1      <= meta_q;
                wd_q.m0.sop  <= first;
                wd_q.m0.data <= first ? {d[511:256], meta_q.sig_l} : d;
                if (first) begin
                    wd_q.m0.sig_h <= d[255:0];
                    wd_q.m0.pub   <= d[511:256];
                end
            end
            if (wr_q && full) ovf <= 1'b1;
        end
    end

    showahead_fifo #(.WIDTH($bits(pcie_tr_word_t)), .DEPTH(BUFF_SZ)) u_fifo (
        .clock (clk),
        .aclr  (!rst_n),
        .data  (wd_q),
        .wrreq (wr_q && !full),
        .rdreq (rd),
        .q     (q),
        .empty (empty),
        .full  (full),
        .usedw (fill)
    );

`ifdef PCIE_TR_EXT_MC_STATS_EN
    logic [1:0]  err_inc;
    logic [32:0] err_sum;

    // A bad header and an overflowing write can land in the same cycle, so errors may step by two.
    assign err_inc = 2'(hdr && (hd.size == '0 || tc > 16'(MAX_BEATS))) + 2'(wr_q && full);
    assign err_sum = {1'b0, err_cnt} + 33'(err_inc);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_cnt <= '0;
            err_cnt <= '0;
        end else begin
            if (wr_q && !full && wd_q.eop && pkt_cnt != '1) pkt_cnt <= pkt_cnt + 32'd1;
            err_cnt <= err_sum[32] ? '1 : err_sum[31:0];
        end
    end
`endif

endmodule

// File: rtl/showahead_fifo.sv
// showahead_fifo: single-clock FIFO whose head word is visible on q before rdreq; aclr clears the pointers.
module showahead_fifo #(
    parameter int  WIDTH = 8,
    parameter int  DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             aclr,
    input  logic [WIDTH-1:0] data,
    input  logic             wrreq,
    input  logic             rdreq,
    output logic [WIDTH-1:0] q,
    output logic             empty,
    output logic             full,
    output logic [AW:0]      usedw
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp, rp;
    logic             wr, rd;

    assign empty = usedw == '0;
    assign full  = usedw == (AW+1)'(DEPTH);
    assign wr    = wrreq && !full;
    assign rd    = rdreq && !empty;
    assign q     = mem[rp];

    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            wp    <= '0;
            rp    <= '0;
            usedw <= '0;
        end else begin
            if (wr) wp <= wp + 1'b1;
            if (rd) rp <= rp + 1'b1;
            usedw <= usedw + {{AW{1'b0}}, wr} - {{AW{1'b0}}, rd};
        end
    end

    always_ff @(posedge clock) begin
        if (wr) mem[wp] <= data;
    end

endmodule

// File: rtl/pcie_tr_ext_mc.sv
// pcie_tr_ext_mc: multi-channel PCIe transaction extractor with a packet-atomic round-robin output arbiter.
// Define PCIE_TR_EXT_MC_STATS_EN to add the pkt_cnt / err_cnt statistics outputs.
module pcie_tr_ext_mc
    import wd_sigverify::*;
#(
    parameter int          N_CH      = 2,
    parameter int          BUFF_SZ   = 1024,
    parameter int          MAX_BEATS = 16,
    parameter logic [63:0] TID_INIT  = 64'hABCD_0000,
    localparam int         BUFF_SZ_L = $clog2(BUFF_SZ),
    localparam int         CW        = N_CH > 1 ? $clog2(N_CH) : 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [N_CH-1:0]                pcie_v,
    input  logic [N_CH*512-1:0]            pcie_d,
    output logic [N_CH-1:0]                pcie_f,
    output logic [N_CH*(BUFF_SZ_L+1)-1:0]  pcie_l,
    output logic [N_CH-1:0]                ovf,
    output logic                           o_v,
    input  logic                           o_r,
    output logic                           o_e,
    output logic [CW-1:0]                  o_ch,
    output logic [$bits(sv_meta2_t)-1:0]   o_m0,
    output logic [$bits(pcie_meta_t)-1:0]  o_m1
`ifdef PCIE_TR_EXT_MC_STATS_EN
    ,
    output logic [N_CH*32-1:0]             pkt_cnt,
    output logic [N_CH*32-1:0]             err_cnt
`endif
);

    pcie_tr_word_t   q [N_CH];
    logic [N_CH-1:0] emp, rd;
    logic            lock;
    logic [CW-1:0]   gnt, ptr, pick, cur;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        pcie_tr_ch #(
            .BUFF_SZ   (BUFF_SZ),
            .MAX_BEATS (MAX_BEATS),
            .TID_RST   (TID_INIT + (64'(c) << 56))
        ) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .v       (pcie_v[c]),
            .d       (pcie_d[c*512+:512]),
            .rd      (rd[c]),
            .q       (q[c]),
            .empty   (emp[c]),
            .full    (pcie_f[c]),
            .fill    (pcie_l[c*(BUFF_SZ_L+1)+:BUFF_SZ_L+1]),
            .ovf     (ovf[c])
`ifdef PCIE_TR_EXT_MC_STATS_EN
            ,
            .pkt_cnt (pkt_cnt[c*32+:32]),
            .err_cnt (err_cnt[c*32+:32])
`endif
        );
        assign rd[c] = o_v && o_r && cur == CW'(c);
    end

    // First non-empty channel at or after ptr; descending loop so the nearest one wins.
    always_comb begin
        pick = ptr;
        for (int i = N_CH - 1; i >= 0; i--)
            if (!emp[(int'(ptr) + i) % N_CH]) pick = CW'((int'(ptr) + i) % N_CH);
    end

    assign cur  = lock ? gnt : pick;
    assign o_v  = !emp[cur];
    assign o_ch = cur;
    assign o_e  = q[cur].eop;
    assign o_m0 = q[cur].m0;
    assign o_m1 = q[cur].m1;

    // Any presented beat that does not close its packet locks the grant, keeping outputs stable under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock <= 1'b0;
            gnt  <= '0;
            ptr  <= '0;
        end else if (o_v) begin
            if (o_r && o_e) begin
                lock <= 1'b0;
                ptr  <= CW'((int'(cur) + 1) % N_CH);
            end else begin
                lock <= 1'b1;
                gnt  <= cur;
            end
        end
    end

endmodule

// File: tb/tb_pcie_tr_ext_mc.sv
// tb_pcie_tr_ext_mc: packet table plus hand sequences, checked by a per-channel scoreboard on the output port.
module tb_pcie_tr_ext_mc;
    import wd_sigverify::*;

    localparam int          NC = 2;
    localparam int          LW = 5;
    localparam logic [63:0] TI = 64'hABCD_0000;
    localparam logic [63:0] T1 = TI + (64'd1 << 56);

    typedef struct {
        int          ch;
        int          size;
        int          nb;
        bit          stray;
        logic [63:0] tid;
        int          emp;
        int          nout;
    } pkt_t;

    typedef struct {
        logic         eop;
        logic         sop;
        logic [511:0] data;
        logic [255:0] sig_h;
        logic [255:0] pub;
        logic [63:0]  tid;
        logic [5:0]   emp;
        logic [15:0]  size;
    } exp_t;

    logic                  clk = 0;
    logic                  rst_n = 0;
    logic                  v_a [NC];
    logic [511:0]          d_a [NC];
    logic [NC-1:0]         pcie_v;
    logic [NC*512-1:0]     pcie_d;
    logic [NC-1:0]         pcie_f, ovf;
    logic [NC*LW-1:0]      pcie_l;
    logic                  o_v, o_r, o_e;
    logic [0:0]            o_ch;
    logic [$bits(sv_meta2_t)-1:0]  o_m0;
    logic [$bits(pcie_meta_t)-1:0] o_m1;
`ifdef PCIE_TR_EXT_MC_STATS_EN
    logic [NC*32-1:0]      pkt_cnt, err_cnt;
`endif

    int   n_cmp = 0, n_bad = 0, k = 0;
    exp_t sb [NC][$];
    exp_t e_s;
    sv_meta2_t  m0_s, hold;
    pcie_meta_t m1_s;
    logic busy = 0, seen = 0;
    logic [0:0] busy_ch = 0, first_ch = 0;

    assign pcie_v = {v_a[1], v_a[0]};
    assign pcie_d = {d_a[1], d_a[0]};

    always #5 clk = ~clk;

    pcie_tr_ext_mc #(.N_CH(NC), .BUFF_SZ(16), .MAX_BEATS(16), .TID_INIT(TI)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .pcie_v (pcie_v),
        .pcie_d (pcie_d),
        .pcie_f (pcie_f),
        .pcie_l (pcie_l),
        .ovf    (ovf),
        .o_v    (o_v),
        .o_r    (o_r),
        .o_e    (o_e),
        .o_ch   (o_ch),
        .o_m0   (o_m0),
        .o_m1   (o_m1)
`ifdef PCIE_TR_EXT_MC_STATS_EN
        ,
        .pkt_cnt (pkt_cnt),
        .err_cnt (err_cnt)
`endif
    );

    task automatic chk(input string nm, input logic [511:0] a, input logic [511:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, a, e);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && o_v && o_r) begin
            m0_s = o_m0;
            m1_s = o_m1;
            if (!seen) begin
                seen = 1;
                first_ch = o_ch;
            end
            if (busy) chk("no interleave o_ch", o_ch, busy_ch);
            if (sb[o_ch].size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected beat: got ch %0d expected none", o_ch);
            end else begin
                e_s = sb[o_ch].pop_front();
                chk("o_e", o_e, e_s.eop);
                chk("sop", m0_s.sop, e_s.sop);
                chk("data", m0_s.data, e_s.data);
                chk("tid", m1_s.tid, e_s.tid);
                chk("emp", m1_s.emp, e_s.emp);
                chk("size", m1_s.size, e_s.size);
                if (e_s.sop) begin
                    chk("sig_h", m0_s.sig_h, e_s.sig_h);
                    chk("pub", m0_s.pub, e_s.pub);
                end
            end
            busy = !o_e;
            busy_ch = o_ch;
        end
    end

    task automatic beat(input int c, input logic [511:0] d);
        @(posedge clk);
        #1;
        v_a[c] = 1;
        d_a[c] = d;
    endtask

    task automatic idle_all();
        @(posedge clk);
        #1;
        for (int c = 0; c < NC; c++) v_a[c] = 0;
    endtask

    task automatic send_pkt(input int c, input int size, input int nb, input logic [63:0] tid,
                            input int emp, input int nout, input bit stray);
        pcie_meta_t   h;
        exp_t         e;
        logic [511:0] bd;
        k++;
        if (stray) begin
            h = '0;
            h.magic = 32'h0BAD_F00D;
            h.size = 16'd64;
            beat(c, h);
        end
        h = '0;
        h.magic = PCIE_MAGIC;
        h.size = 16'(size);
        h.src = 16'(k);
        h.sig_l = {8{16'hC0DE, 16'(k)}};
        beat(c, h);
        for (int b = 1; b <= nb; b++) begin
            bd = {16{8'(k), 8'(b), 16'h5A5A}};
            if (b <= nout) begin
                e.eop = b == nout;
                e.sop = b == 1;
                e.data = b == 1 ? {bd[511:256], h.sig_l} : bd;
                e.sig_h = bd[255:0];
                e.pub = bd[511:256];
                e.tid = tid;
                e.emp = 6'(emp);
                e.size = 16'(size);
                sb[c].push_back(e);
            end
            beat(c, bd);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 0;
        for (int c = 0; c < NC; c++) v_a[c] = 0;
        repeat (2) @(posedge clk);
        #1;
        for (int c = 0; c < NC; c++) sb[c].delete();
        busy = 0;
        seen = 0;
        chk("reset o_v", o_v, 0);
        chk("reset ovf", ovf, 0);
        chk("reset pcie_f", pcie_f, 0);
        chk("reset pcie_l", pcie_l, 0);
        rst_n = 1;
    endtask

    task automatic drain();
        int n = 0;
        while (sb[0].size() + sb[1].size() != 0 && n < 400) begin
            @(posedge clk);
            n++;
        end
        if (n >= 400) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain timeout: got %0d beats pending expected 0", sb[0].size() + sb[1].size());
        end
        repeat (3) @(posedge clk);
        #1;
        chk("idle o_v", o_v, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        pkt_t tbl [5];
        tbl[0] = '{0, 200, 4, 0, TI, 56, 4};
        tbl[1] = '{0, 64, 1, 1, TI + 1, 0, 1};
        tbl[2] = '{0, 0, 0, 0, TI + 2, 0, 0};
        tbl[3] = '{0, 64 * 17, 17, 0, TI + 3, 0, 0};
        tbl[4] = '{0, 64, 1, 0, TI + 4, 0, 1};
        for (int c = 0; c < NC; c++) begin
            v_a[c] = 0;
            d_a[c] = '0;
        end
        o_r = 1;
        do_reset();

        for (int i = 0; i < 5; i++)
            send_pkt(tbl[i].ch, tbl[i].size, tbl[i].nb, tbl[i].tid, tbl[i].emp, tbl[i].nout, tbl[i].stray);
        idle_all();
        drain();
        chk("ovf after table", ovf, 0);
`ifdef PCIE_TR_EXT_MC_STATS_EN
        chk("err_cnt ch0", err_cnt[31:0], 2);
        chk("pkt_cnt ch0", pkt_cnt[31:0], 3);
`endif

        o_r = 0;
        send_pkt(0, 1024, 16, TI + 5, 0, 16, 0);
        hold = o_m0;
        chk("backpressure o_v", o_v, 1);
        send_pkt(0, 256, 4, TI + 6, 0, 0, 0);
        idle_all();
        repeat (3) @(posedge clk);
        #1;
        chk("pcie_f full", pcie_f, 2'b01);
        chk("ovf sticky", ovf, 2'b01);
        chk("fill ch0", pcie_l[LW-1:0], 16);
        chk("fill ch1", pcie_l[2*LW-1:LW], 0);
        chk("o_m0 stable", o_m0, hold);
        chk("o_ch stable", o_ch, 0);
        o_r = 1;
        drain();
        chk("ovf held", ovf, 2'b01);

        o_r = 0;
        send_pkt(0, 256, 2, TI, 0, 0, 0);
        idle_all();
        repeat (2) @(posedge clk);
        #1;
        chk("partial visible", o_v, 1);
        do_reset();
        o_r = 1;
        send_pkt(0, 256, 4, TI, 0, 4, 0);
        idle_all();
        drain();

        do_reset();
        fork
            send_pkt(0, 128, 2, TI, 0, 2, 0);
            send_pkt(1, 128, 2, T1, 0, 2, 0);
        join
        idle_all();
        drain();
        chk("first channel", first_ch, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
